afe_spi_cmd_master: RTL and testbench

Parametrised serial command master for the AFE control port. It accepts a command word over a valid/ready handshake and shifts it out MSB-first or LSB-first. It generates chip-select, a divided serial clock and data with programmable setup, hold and dead-time. With readback compiled in, it captures the AFE response word on the same transaction. It sits between the register/sequencer logic and the AFE pins, on the system clock domain.

---
 rtl/afe_spi_pkg.sv | 26 ++
 rtl/afe_spi_cmd_master_if.sv | 11 +
 rtl/afe_spi_sclk_gen.sv | 41 ++++
 rtl/afe_spi_cmd_master.sv | 159 +++++++++++++++
 tb/tb_afe_spi_cmd_master.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_spi_pkg.sv
// Shared types and elaboration helpers for the AFE serial command master.
package afe_spi_pkg;

  localparam int AFE_SPI_MAX_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DEAD
  } afe_spi_state_t;

  function automatic bit afe_spi_params_ok(int word_w, int clk_div, int cs_setup,
                                           int cs_hold, int deadtime);
    return (word_w >= 2) && (word_w <= AFE_SPI_MAX_WORD_W) && (clk_div >= 1) &&
           (cs_setup >= 1) && (cs_hold >= 1) && (deadtime >= 0);
  endfunction

  function automatic int afe_spi_max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/afe_spi_cmd_master_if.sv
// Command handshake between the register/sequencer logic and the AFE serial master.
interface afe_spi_cmd_master_if #(
  parameter int WORD_W = 20
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WORD_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/afe_spi_sclk_gen.sv
// Divided serial clock for the AFE port: idles low, runs only while 'run' is high,
// and flags the clk edge on which sclk will rise or fall.
module afe_spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int              PH_W    = $clog2(CLK_DIV + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase;
  logic            phase_end;

  // Strobes announce the toggle that happens on the coming clk edge.
  assign phase_end = run && (phase == PH_LAST);
  assign rise_stb  = phase_end && !sclk;
  assign fall_stb  = phase_end && sclk;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else if (!run) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else if (phase_end) begin
      phase <= '0;
      sclk  <= ~sclk;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/afe_spi_cmd_master.sv
// Serial command master for the AFE control port (SPI mode 0, configurable bit order).
// Response capture on miso/rd_data is compiled in with AFE_SPI_READBACK_EN.
module afe_spi_cmd_master
  import afe_spi_pkg::*;
#(
  parameter int WORD_W    = 20,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 1,
  parameter int CS_HOLD   = 1,
  parameter int DEADTIME  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  afe_spi_cmd_master_if.slave cmd,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi
`ifdef AFE_SPI_READBACK_EN
  ,
  input  logic              miso,
  output logic [WORD_W-1:0] rd_data
`endif
);

  localparam int BC_W  = $clog2(WORD_W);
  localparam int TMR_W = $clog2(afe_spi_max3(CS_SETUP, CS_HOLD, DEADTIME) + 1);

  localparam logic [BC_W-1:0]  BIT_LOAD   = BC_W'(WORD_W - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] DEAD_LOAD  = (DEADTIME > 0) ? TMR_W'(DEADTIME - 1) : '0;

  if (!afe_spi_params_ok(WORD_W, CLK_DIV, CS_SETUP, CS_HOLD, DEADTIME)) begin : g_param_check
    $error("afe_spi_cmd_master: illegal parameter set");
  end

  afe_spi_state_t    state;
  logic [BC_W-1:0]   bit_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [WORD_W-1:0] tx_sr;
  logic              accept;
  logic              hold_end;
  logic              rise_stb;
  logic              fall_stb;

  assign cmd.cmd_ready = (state == IDLE) && enable;
  assign accept        = cmd.cmd_valid && (state == IDLE) && enable;
  assign hold_end      = (state == HOLD) && (tmr == '0);

  afe_spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (state == SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tmr     <= '0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= (MSB_FIRST != 0) ? cmd.cmd_data[WORD_W-1] : cmd.cmd_data[0];
            bit_cnt <= BIT_LOAD;
            tmr     <= SETUP_LOAD;
          end
        end
        SETUP: begin
          if (tmr == '0) state <= SHIFT;
          else           tmr   <= tmr - 1'b1;
        end
        SHIFT: begin
          // The final falling edge ends the word; mosi keeps the last bit.
          if (fall_stb) begin
            if (bit_cnt == '0) begin
              state <= HOLD;
              tmr   <= HOLD_LOAD;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              mosi    <= (MSB_FIRST != 0) ? tx_sr[WORD_W-2] : tx_sr[1];
            end
          end
        end
        HOLD: begin
          if (hold_end) begin
            cs_n <= 1'b1;
            done <= 1'b1;
            if (DEADTIME > 0) begin
              state <= DEAD;
              tmr   <= DEAD_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DEAD: begin
          if (tmr == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shift register has no reset; it is always loaded on accept before any bit is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= cmd.cmd_data;
    end else if ((state == SHIFT) && fall_stb && (bit_cnt != '0)) begin
      tx_sr <= (MSB_FIRST != 0) ? {tx_sr[WORD_W-2:0], 1'b0} : {1'b0, tx_sr[WORD_W-1:1]};
    end
  end

`ifdef AFE_SPI_READBACK_EN
  logic [WORD_W-1:0] rx_sr;

  // Response bits are assembled in the same order the command bits leave.
  always_ff @(posedge clk) begin
    if (rise_stb) begin
      rx_sr <= (MSB_FIRST != 0) ? {rx_sr[WORD_W-2:0], miso} : {miso, rx_sr[WORD_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      rd_data <= '0;
    else if (hold_end) rd_data <= rx_sr;
  end
`else
  logic unused_rise_stb;
  assign unused_rise_stb = rise_stb;
`endif

endmodule

// File: tb/tb_afe_spi_cmd_master.sv
// Directed bench for afe_spi_cmd_master: three parameterisations share one clock and reset.
module tb_afe_spi_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic en_a, en_b, en_c;
  logic busy_a, done_a, cs_n_a, sclk_a, mosi_a;
  logic busy_b, done_b, cs_n_b, sclk_b, mosi_b;
  logic busy_c, done_c, cs_n_c, sclk_c, mosi_c;
`ifdef AFE_SPI_READBACK_EN
  logic        miso_a;
  logic [19:0] rd_a;
  logic [7:0]  rd_b;
  logic [19:0] rd_c;
`endif

  afe_spi_cmd_master_if #(.WORD_W(20)) if_a ();
  afe_spi_cmd_master_if #(.WORD_W(8))  if_b ();
  afe_spi_cmd_master_if #(.WORD_W(20)) if_c ();

  afe_spi_cmd_master #(.WORD_W(20)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .cmd(if_a.slave),
    .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a), .mosi(mosi_a)
`ifdef AFE_SPI_READBACK_EN
    , .miso(miso_a), .rd_data(rd_a)
`endif
  );

  afe_spi_cmd_master #(.WORD_W(8), .CLK_DIV(1), .MSB_FIRST(0)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .cmd(if_b.slave),
    .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b)
`ifdef AFE_SPI_READBACK_EN
    , .miso(1'b0), .rd_data(rd_b)
`endif
  );

  afe_spi_cmd_master #(.WORD_W(20), .DEADTIME(0)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .cmd(if_c.slave),
    .busy(busy_c), .done(done_c), .cs_n(cs_n_c), .sclk(sclk_c), .mosi(mosi_c)
`ifdef AFE_SPI_READBACK_EN
    , .miso(1'b0), .rd_data(rd_c)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Monitor mux: the selected DUT's outputs
  int   sel = 0;
  logic s_cs_n, s_sclk, s_mosi, s_done, s_busy, s_ready;
  always_comb begin
    s_cs_n = cs_n_a; s_sclk = sclk_a; s_mosi = mosi_a;
    s_done = done_a; s_busy = busy_a; s_ready = if_a.cmd_ready;
    case (sel)
      1: begin
        s_cs_n = cs_n_b; s_sclk = sclk_b; s_mosi = mosi_b;
        s_done = done_b; s_busy = busy_b; s_ready = if_b.cmd_ready;
      end
      2: begin
        s_cs_n = cs_n_c; s_sclk = sclk_c; s_mosi = mosi_c;
        s_done = done_c; s_busy = busy_c; s_ready = if_c.cmd_ready;
      end
      default: ;
    endcase
  end

  int          r_cs_low, r_rises, r_first_rise_k, r_done_cnt, r_done_k;
  int          r_first_ready_k, r_cs_rise_k, r_cs_refall_k, r_ready_after_drop;
  logic [63:0] r_word;
  logic [19:0] r_rd_at_done;

  task automatic drive(input int s, input logic v, input logic [19:0] d);
    case (s)
      1:       begin if_b.cmd_valid = v; if_b.cmd_data = d[7:0]; end
      2:       begin if_c.cmd_valid = v; if_c.cmd_data = d; end
      default: begin if_a.cmd_valid = v; if_a.cmd_data = d; end
    endcase
  endtask

  task automatic set_en(input int s, input logic e);
    case (s)
      1:       en_b = e;
      2:       en_c = e;
      default: en_a = e;
    endcase
  endtask

  // Offers d1 (swapped to d2 right after the accept), drops valid at release_k,
  // optionally drops enable after drop_rise sclk rises, and records ncyc samples.
  task automatic run_txn(input int s, input logic [19:0] d1, input logic [19:0] d2,
                         input logic [19:0] rsp, input int release_k, input int drop_rise,
                         input int ncyc);
    logic prev_sclk, prev_cs_n, dropped;
    sel = s;
    r_cs_low = 0; r_rises = 0; r_first_rise_k = -1; r_done_cnt = 0; r_done_k = -1;
    r_first_ready_k = -1; r_cs_rise_k = -1; r_cs_refall_k = -1; r_ready_after_drop = 0;
    r_word = '0; r_rd_at_done = '0;
    prev_sclk = 1'b0; prev_cs_n = 1'b1; dropped = 1'b0;
    @(negedge clk);
    drive(s, 1'b1, d1);
`ifdef AFE_SPI_READBACK_EN
    if (s == 0) miso_a = rsp[19];
`endif
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) drive(s, 1'b1, d2);
      if (k == release_k) drive(s, 1'b0, d2);
      if (!s_cs_n) r_cs_low++;
      if (s_sclk && !prev_sclk) begin
        r_rises++;
        r_word = {r_word[62:0], s_mosi};
        if (r_first_rise_k < 0) r_first_rise_k = k;
      end
      if (s_cs_n && !prev_cs_n && r_cs_rise_k < 0) r_cs_rise_k = k;
      if (!s_cs_n && prev_cs_n && r_cs_rise_k >= 0 && r_cs_refall_k < 0) r_cs_refall_k = k;
      if (s_done) begin
        r_done_cnt++;
        if (r_done_k < 0) begin
          r_done_k = k;
`ifdef AFE_SPI_READBACK_EN
          if (s == 0) r_rd_at_done = rd_a;
`endif
        end
      end
      if (s_ready && r_first_ready_k < 0) r_first_ready_k = k;
      if (dropped && s_ready) r_ready_after_drop++;
      if (drop_rise > 0 && !dropped && r_rises == drop_rise) begin
        set_en(s, 1'b0);
        dropped = 1'b1;
      end
`ifdef AFE_SPI_READBACK_EN
      if (s == 0) miso_a = (r_rises < 20) ? rsp[19 - r_rises] : 1'b0;
`endif
      prev_sclk = s_sclk;
      prev_cs_n = s_cs_n;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    drive(0, 1'b0, '0); drive(1, 1'b0, '0); drive(2, 1'b0, '0);
`ifdef AFE_SPI_READBACK_EN
    miso_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests++; if (cs_n_a !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
    tests++; if (sclk_a !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    tests++; if (mosi_a !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (if_a.cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_disabled: got %b want 0", if_a.cmd_ready); end
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    #1;
    tests++; if (if_a.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_enabled: got %b want 1", if_a.cmd_ready); end
`ifdef AFE_SPI_READBACK_EN
    tests++; if ({rd_a, rd_b, rd_c} !== '0) begin fails++; $display("FAIL reset_rd_data: got %h/%h/%h want 0", rd_a, rd_b, rd_c); end
`endif
  endtask

  task automatic test_basic();
    run_txn(0, 20'hA5F0C, 20'h5A0F3, 20'h3C3C3, 0, 0, 90);
    tests++; if (r_word[19:0] !== 20'hA5F0C) begin fails++; $display("FAIL basic_mosi: got %h want a5f0c", r_word[19:0]); end
    tests++; if (r_rises !== 20) begin fails++; $display("FAIL basic_sclk_pulses: got %0d want 20", r_rises); end
    tests++; if (r_cs_low !== 82) begin fails++; $display("FAIL basic_cs_low: got %0d want 82", r_cs_low); end
    tests++; if (r_first_rise_k !== 3) begin fails++; $display("FAIL basic_first_rise: got %0d want 3", r_first_rise_k); end
    tests++; if (r_done_cnt !== 1) begin fails++; $display("FAIL basic_done_cnt: got %0d want 1", r_done_cnt); end
    tests++; if (r_done_k !== 82) begin fails++; $display("FAIL basic_done_cycle: got %0d want 82", r_done_k); end
    tests++; if (r_first_ready_k !== 84) begin fails++; $display("FAIL basic_next_ready: got %0d want 84", r_first_ready_k); end
`ifdef AFE_SPI_READBACK_EN
    tests++; if (r_rd_at_done !== 20'h3C3C3) begin fails++; $display("FAIL readback: got %h want 3c3c3", r_rd_at_done); end
`endif
  endtask

  task automatic test_lsb_first();
    run_txn(1, 20'h00001, 20'h000FE, 20'h0, 0, 0, 25);
    tests++; if (r_word[7:0] !== 8'h80) begin fails++; $display("FAIL lsb_bits: got %h want 80", r_word[7:0]); end
    tests++; if (r_rises !== 8) begin fails++; $display("FAIL lsb_sclk_pulses: got %0d want 8", r_rises); end
    tests++; if (r_cs_low !== 18) begin fails++; $display("FAIL lsb_cs_low: got %0d want 18", r_cs_low); end
    tests++; if (r_done_cnt !== 1) begin fails++; $display("FAIL lsb_done_cnt: got %0d want 1", r_done_cnt); end
  endtask

  task automatic test_back_to_back();
    run_txn(2, 20'h00001, 20'hFFFFF, 20'h0, 83, 0, 170);
    tests++; if (r_word[39:0] !== {20'h00001, 20'hFFFFF}) begin fails++; $display("FAIL b2b_mosi: got %h want 00001fffff", r_word[39:0]); end
    tests++; if (r_rises !== 40) begin fails++; $display("FAIL b2b_sclk_pulses: got %0d want 40", r_rises); end
    tests++; if (r_cs_rise_k !== 82) begin fails++; $display("FAIL b2b_cs_rise: got %0d want 82", r_cs_rise_k); end
    tests++; if (r_cs_refall_k !== 83) begin fails++; $display("FAIL b2b_cs_refall: got %0d want 83", r_cs_refall_k); end
    tests++; if (r_cs_low !== 164) begin fails++; $display("FAIL b2b_cs_low: got %0d want 164", r_cs_low); end
    tests++; if (r_done_cnt !== 2) begin fails++; $display("FAIL b2b_done_cnt: got %0d want 2", r_done_cnt); end
  endtask

  task automatic test_enable_drop();
    run_txn(0, 20'h5A5A5, 20'h5A5A5, 20'h0, -1, 5, 100);
    tests++; if (r_word[19:0] !== 20'h5A5A5) begin fails++; $display("FAIL endrop_mosi: got %h want 5a5a5", r_word[19:0]); end
    tests++; if (r_rises !== 20) begin fails++; $display("FAIL endrop_sclk_pulses: got %0d want 20", r_rises); end
    tests++; if (r_cs_low !== 82) begin fails++; $display("FAIL endrop_cs_low: got %0d want 82", r_cs_low); end
    tests++; if (r_done_cnt !== 1) begin fails++; $display("FAIL endrop_done_cnt: got %0d want 1", r_done_cnt); end
    tests++; if (r_ready_after_drop !== 0) begin fails++; $display("FAIL endrop_ready: got %0d ready cycles want 0", r_ready_after_drop); end
    drive(0, 1'b0, '0);
    en_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    int   rises;
    int   dones;
    logic prev_sclk;
    rises = 0; dones = 0; prev_sclk = 1'b0;
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 20'hA5F0C);
    for (int k = 0; k < 200 && rises < 10; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, 1'b0, 20'hA5F0C);
      if (sclk_a && !prev_sclk) rises++;
      prev_sclk = sclk_a;
    end
    tests++; if (rises !== 10) begin fails++; $display("FAIL midrst_reach_bit10: got %0d rises want 10", rises); end
    tests++; if ({cs_n_a, sclk_a, mosi_a} !== 3'b011) begin fails++; $display("FAIL midrst_pre: got cs_n/sclk/mosi %b want 011", {cs_n_a, sclk_a, mosi_a}); end
    reset_n = 1'b0;
    #1;
    tests++; if ({cs_n_a, sclk_a, mosi_a, busy_a} !== 4'b1000) begin fails++; $display("FAIL midrst_outputs: got cs_n/sclk/mosi/busy %b want 1000", {cs_n_a, sclk_a, mosi_a, busy_a}); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d done cycles want 0", dones); end
    run_txn(0, 20'h12345, 20'hEDCBA, 20'h3C3C3, 0, 0, 90);
    tests++; if (r_word[19:0] !== 20'h12345) begin fails++; $display("FAIL midrst_next_mosi: got %h want 12345", r_word[19:0]); end
    tests++; if (r_cs_low !== 82) begin fails++; $display("FAIL midrst_next_cs_low: got %0d want 82", r_cs_low); end
    tests++; if (r_done_cnt !== 1) begin fails++; $display("FAIL midrst_next_done: got %0d want 1", r_done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
